// File: rtl/fm_demod_pkg.sv
// Shared definitions for the FM period demodulator.
// Holds the zero-crossing sign state encoding, the helper that gives the
// divider iteration count, and the default dividend width.
package fm_demod_pkg;

   // Sign tracker state. UNK means no valid sign is known yet, either after
   // reset or after a timeout.
   typedef enum logic [1:0] {
      SIGN_UNK = 2'd0,
      SIGN_NEG = 2'd1,
      SIGN_POS = 2'd2
   } sign_t;

   // The dividend is 2^(nbits_phase+avg_log2). It needs nbits_phase+avg_log2+1
   // bits, and the restoring divider retires one of those bits per clock.
   function automatic int div_cycles(input int nbits_phase, input int avg_log2);
      return nbits_phase + avg_log2 + 1;
   endfunction

   // Dividend width for the default configuration (18-bit phase, no averaging).
   localparam int DIVIDEND_W = div_cycles(18, 0);

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider that produces one quotient bit per clock.
// Ports:
//  clock, reset   system clock, synchronous active-high reset
//  start          load dividend/divisor and begin (ignored while abort is high)
//  abort          drop any divide in progress, no done pulse
//  dividend       DVD_W-bit unsigned dividend
//  divisor        DSR_W-bit unsigned divisor (caller guarantees non-zero)
//  busy           high while iterations remain
//  done           one-clock pulse when quotient is final
//  quotient       DVD_W-bit quotient, valid while done is high
module seq_divider
   import fm_demod_pkg::*;
#(
   parameter int DVD_W = DIVIDEND_W,
   parameter int DSR_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DSR_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient
);

   localparam int CW = $clog2(DVD_W + 1);

   logic [DSR_W-1:0] rem;
   logic [DVD_W-1:0] q_shift;
   logic [DSR_W-1:0] dsr;
   logic [CW-1:0]    steps;
   logic [DSR_W:0]   rem_sh;
   logic             ge;

   // The partial remainder always stays below the divisor, so one extra bit
   // is enough to hold it after shifting in the next dividend bit.
   always_comb begin
      rem_sh = {rem, q_shift[DVD_W-1]};
      ge     = (rem_sh >= {1'b0, dsr});
   end

   // The dividend shifts out of the top of q_shift while quotient bits shift
   // in at the bottom, so after DVD_W steps q_shift holds the quotient.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         rem     <= '0;
         q_shift <= '0;
         dsr     <= '0;
         steps   <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            busy <= 1'b0;
         end else if (start) begin
            busy    <= 1'b1;
            rem     <= '0;
            q_shift <= dividend;
            dsr     <= divisor;
            steps   <= CW'(DVD_W);
         end else if (busy) begin
            rem     <= ge ? DSR_W'(rem_sh - {1'b0, dsr}) : rem_sh[DSR_W-1:0];
            q_shift <= {q_shift[DVD_W-2:0], ge};
            steps   <= steps - 1'b1;
            if (steps == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quotient = q_shift;

endmodule

// File: rtl/fm_period_demod.sv
// FM period demodulator: measures the number of samples between rising zero
// crossings and converts that period to the equivalent DDS phase increment,
// 2^NBITS_PHASE / period.
// Ports:
//  clock, reset   system clock, synchronous active-high reset
//  enableclk      sample strobe, insample is valid only when high
//  insample       32-bit signed sample
//  phaseinc_out   estimated phase increment, held between updates
//  period_out     last summed period in samples (saturating)
//  valid          one-clock pulse when phaseinc_out/period_out update
//  locked         high after a good estimate, cleared by timeout
//  timeout        one-clock pulse with valid when the period counter saturates
//  overrun        sticky, a period closed while the divider was still busy
module fm_period_demod
   import fm_demod_pkg::*;
#(
   parameter int NBITS_PHASE = 18,
   parameter int CNT_W       = 16,
   parameter int AVG_LOG2    = 0,
   parameter int HYST        = 1024
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enableclk,
   input  logic signed [31:0] insample,
   output logic [31:0]        phaseinc_out,
   output logic [CNT_W-1:0]   period_out,
   output logic               valid,
   output logic               locked,
   output logic               timeout,
   output logic               overrun
);

   localparam int DIV_W = div_cycles(NBITS_PHASE, AVG_LOG2);
   localparam int SUM_W = CNT_W + AVG_LOG2;
   localparam int NW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [NW-1:0]     LAST_IDX = NW'((1 << AVG_LOG2) - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [DIV_W-1:0]  DIVIDEND = {1'b1, {(DIV_W-1){1'b0}}};
   localparam logic signed [31:0] HYST_POS = 32'(HYST);
   localparam logic signed [31:0] HYST_NEG = -HYST_POS;

   sign_t            state;
   sign_t            state_next;
   logic             is_pos;
   logic             is_neg;
   logic             armed;
   logic [CNT_W-1:0] cnt;
   logic [SUM_W-1:0] acc;
   logic [NW-1:0]    acc_n;
   logic [SUM_W-1:0] div_sum;
   logic [SUM_W:0]   sum_wide;
   logic [SUM_W-1:0] sum_sat;
   logic             timeout_fire;
   logic             crossing;
   logic             last_period;
   logic             div_start;
   logic             div_busy;
   logic             div_done;
   logic [DIV_W-1:0] div_quotient;
   logic [63:0]      q_wide;
   logic [31:0]      phase_next;
   logic [CNT_W-1:0] period_sat;

   // Hysteresis thresholds and the event decodes. A timeout on this sample
   // suppresses any crossing so the re-arm path is the only one taken.
   always_comb begin
      is_pos       = (insample >= HYST_POS);
      is_neg       = (insample <= HYST_NEG);
      timeout_fire = enableclk && armed && (cnt == CNT_MAX);
      crossing     = enableclk && !timeout_fire && (state == SIGN_NEG) && is_pos;
      last_period  = (acc_n == LAST_IDX);
      div_start    = crossing && armed && last_period && !div_busy;
      sum_wide     = {1'b0, acc} + (SUM_W+1)'(cnt);
      sum_sat      = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
   end

   // Sign tracker next state. Only a NEG to POS move counts as a crossing;
   // leaving UNK just establishes the sign.
   always_comb begin
      state_next = state;
      if (enableclk) begin
         if (timeout_fire) begin
            state_next = SIGN_UNK;
         end else begin
            case (state)
               SIGN_UNK: begin
                  if (is_pos)      state_next = SIGN_POS;
                  else if (is_neg) state_next = SIGN_NEG;
               end
               SIGN_POS: if (is_neg) state_next = SIGN_NEG;
               SIGN_NEG: if (is_pos) state_next = SIGN_POS;
               default:  state_next = SIGN_UNK;
            endcase
         end
      end
   end

   // Sign tracker state register.
   always_ff @(posedge clock) begin
      if (reset) state <= SIGN_UNK;
      else       state <= state_next;
   end

   // Period counter and accumulator. The first crossing after reset or a
   // timeout only arms the counter. A completed sum is handed to the divider
   // if it is idle, otherwise it is dropped and overrun is latched.
   always_ff @(posedge clock) begin
      if (reset) begin
         armed   <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         acc_n   <= '0;
         div_sum <= '0;
         overrun <= 1'b0;
      end else if (timeout_fire) begin
         armed <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
         acc_n <= '0;
      end else if (crossing) begin
         cnt <= CNT_W'(1);
         if (!armed) begin
            armed <= 1'b1;
            acc   <= '0;
            acc_n <= '0;
         end else if (last_period) begin
            acc   <= '0;
            acc_n <= '0;
            if (div_busy) overrun <= 1'b1;
            else          div_sum <= sum_sat;
         end else begin
            acc   <= sum_sat;
            acc_n <= acc_n + 1'b1;
         end
      end else if (enableclk && armed && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   seq_divider #(
      .DVD_W (DIV_W),
      .DSR_W (SUM_W)
   ) u_div (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .abort    (timeout_fire),
      .dividend (DIVIDEND),
      .divisor  (sum_sat),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quotient)
   );

   // Saturate the quotient to 32 bits and the summed period to CNT_W bits.
   always_comb begin
      q_wide     = 64'(div_quotient);
      phase_next = (q_wide > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : q_wide[31:0];
      period_sat = ({1'b0, div_sum} > (SUM_W+1)'(CNT_MAX)) ? CNT_MAX : CNT_W'(div_sum);
   end

   // Result registers. Timeout wins over a simultaneous divider result so
   // only a single valid pulse is ever issued.
   always_ff @(posedge clock) begin
      if (reset) begin
         phaseinc_out <= '0;
         period_out   <= '0;
         valid        <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         valid   <= 1'b0;
         timeout <= 1'b0;
         if (timeout_fire) begin
            phaseinc_out <= '0;
            period_out   <= '1;
            valid        <= 1'b1;
            timeout      <= 1'b1;
            locked       <= 1'b0;
         end else if (div_done) begin
            phaseinc_out <= phase_next;
            period_out   <= period_sat;
            valid        <= 1'b1;
            locked       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fm_period_demod.sv
// Self-checking bench for fm_period_demod. Instance a uses the defaults,
// instance b uses CNT_W=8 and AVG_LOG2=1. Expected results are queued as the
// closing sample is driven and compared when valid appears.
module tb_fm_period_demod;

   localparam int D_A = 19;
   localparam int D_B = 20;

   typedef struct {
      logic [31:0] phaseinc;
      logic [31:0] period;
      logic        tmo;
      logic        lck;
      int          cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;

   logic               en_a = 1'b0;
   logic signed [31:0] smp_a = '0;
   logic [31:0]        phaseinc_a;
   logic [15:0]        period_a;
   logic               valid_a, locked_a, timeout_a, overrun_a;

   logic               en_b = 1'b0;
   logic signed [31:0] smp_b = '0;
   logic [31:0]        phaseinc_b;
   logic [7:0]         period_b;
   logic               valid_b, locked_b, timeout_b, overrun_b;

   int   checks = 0;
   int   passes = 0;
   int   cycle  = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;

   fm_period_demod dut_a (
      .clock(clock), .reset(reset), .enableclk(en_a), .insample(smp_a),
      .phaseinc_out(phaseinc_a), .period_out(period_a), .valid(valid_a),
      .locked(locked_a), .timeout(timeout_a), .overrun(overrun_a)
   );

   fm_period_demod #(.CNT_W(8), .AVG_LOG2(1)) dut_b (
      .clock(clock), .reset(reset), .enableclk(en_b), .insample(smp_b),
      .phaseinc_out(phaseinc_b), .period_out(period_b), .valid(valid_b),
      .locked(locked_b), .timeout(timeout_b), .overrun(overrun_b)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cycle <= cycle + 1;

   // Scoreboard for instance a: every valid must match the oldest expectation.
   always @(negedge clock) begin
      if (valid_a) begin
         if (q_a.size() == 0) begin
            checks++;
            $display("[TB] FAIL a_unexpected_valid at cycle %0d phaseinc=%0d required no valid", cycle, phaseinc_a);
         end else begin
            ea = q_a.pop_front();
            checks++;
            if (phaseinc_a !== ea.phaseinc) $display("[TB] FAIL a_phaseinc got %0d want %0d", phaseinc_a, ea.phaseinc);
            else passes++;
            checks++;
            if (32'(period_a) !== ea.period) $display("[TB] FAIL a_period got %0d want %0d", period_a, ea.period);
            else passes++;
            checks++;
            if (timeout_a !== ea.tmo) $display("[TB] FAIL a_timeout got %b want %b", timeout_a, ea.tmo);
            else passes++;
            checks++;
            if (locked_a !== ea.lck) $display("[TB] FAIL a_locked got %b want %b", locked_a, ea.lck);
            else passes++;
            checks++;
            if (cycle !== ea.cyc) $display("[TB] FAIL a_latency valid at cycle %0d want %0d", cycle, ea.cyc);
            else passes++;
         end
      end
   end

   // Scoreboard for instance b.
   always @(negedge clock) begin
      if (valid_b) begin
         if (q_b.size() == 0) begin
            checks++;
            $display("[TB] FAIL b_unexpected_valid at cycle %0d phaseinc=%0d required no valid", cycle, phaseinc_b);
         end else begin
            eb = q_b.pop_front();
            checks++;
            if (phaseinc_b !== eb.phaseinc) $display("[TB] FAIL b_phaseinc got %0d want %0d", phaseinc_b, eb.phaseinc);
            else passes++;
            checks++;
            if (32'(period_b) !== eb.period) $display("[TB] FAIL b_period got %0d want %0d", period_b, eb.period);
            else passes++;
            checks++;
            if (timeout_b !== eb.tmo) $display("[TB] FAIL b_timeout got %b want %b", timeout_b, eb.tmo);
            else passes++;
            checks++;
            if (locked_b !== eb.lck) $display("[TB] FAIL b_locked got %b want %b", locked_b, eb.lck);
            else passes++;
            checks++;
            if (cycle !== eb.cyc) $display("[TB] FAIL b_latency valid at cycle %0d want %0d", cycle, eb.cyc);
            else passes++;
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
      $fatal(1, "[TB] watchdog");
   end

   task automatic reset_dut();
      @(negedge clock);
      reset = 1'b1;
      en_a  = 1'b0;
      en_b  = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // Drive one sample on a, then idle clocks with the strobe low.
   task automatic samp_a(input logic signed [31:0] v, input int idle, output int k);
      @(negedge clock);
      k     = cycle;
      en_a  = 1'b1;
      smp_a = v;
      for (int i = 0; i < idle; i++) begin
         @(negedge clock);
         en_a = 1'b0;
      end
   endtask

   task automatic samp_b(input logic signed [31:0] v, output int k);
      @(negedge clock);
      k     = cycle;
      en_b  = 1'b1;
      smp_b = v;
   endtask

   // Square wave on a starting with the high half. Crossings begin at period
   // 1 (arming) and measurements at period 2. With gap>0 a closing crossing
   // is only expected to start a divide if the previous one is at least gap
   // sample edges earlier.
   task automatic wave_a(input int p, input int idle, input int n_per, input bit band,
                         input logic [31:0] exp_ph, input int gap);
      int k;
      int last_edge;
      logic signed [31:0] v;
      exp_t e;
      last_edge = -100000;
      for (int j = 0; j < n_per; j++) begin
         for (int i = 0; i < p; i++) begin
            if (i < p/2) v = (band && i == 0) ? 32'sd500 : 32'sd30000;
            else         v = (band && i == p/2) ? -32'sd500 : -32'sd30000;
            samp_a(v, idle, k);
            if (j >= 2 && i == (band ? 1 : 0)) begin
               if (gap == 0 || (k + 1) - last_edge >= gap) begin
                  e.phaseinc = exp_ph;
                  e.period   = 32'(p);
                  e.tmo      = 1'b0;
                  e.lck      = 1'b1;
                  e.cyc      = k + D_A + 2;
                  q_a.push_back(e);
                  last_edge = k + 1;
               end
            end
         end
      end
      @(negedge clock);
      en_a = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 200 && (q_a.size() != 0 || q_b.size() != 0); n++) @(posedge clock);
      repeat (3) @(posedge clock);
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         $display("[TB] FAIL %s_pending got %0d/%0d outstanding want 0", name, q_a.size(), q_b.size());
         q_a.delete();
         q_b.delete();
      end else passes++;
   endtask

   task automatic test_reset();
      reset_dut();
      @(negedge clock);
      checks++; if (phaseinc_a !== 32'd0) $display("[TB] FAIL reset_phaseinc got %0d want 0", phaseinc_a); else passes++;
      checks++; if (period_a !== 16'd0)   $display("[TB] FAIL reset_period got %0d want 0", period_a); else passes++;
      checks++; if (valid_a !== 1'b0)     $display("[TB] FAIL reset_valid got %b want 0", valid_a); else passes++;
      checks++; if (locked_a !== 1'b0)    $display("[TB] FAIL reset_locked got %b want 0", locked_a); else passes++;
      checks++; if (timeout_a !== 1'b0)   $display("[TB] FAIL reset_timeout got %b want 0", timeout_a); else passes++;
      checks++; if (overrun_a !== 1'b0)   $display("[TB] FAIL reset_overrun got %b want 0", overrun_a); else passes++;
      checks++; if ({phaseinc_b, period_b, locked_b, overrun_b} !== '0)
         $display("[TB] FAIL reset_b_outputs got %h want 0", {phaseinc_b, period_b, locked_b, overrun_b}); else passes++;
   endtask

   task automatic test_loopback();
      reset_dut();
      wave_a(64, 0, 5, 1'b1, 32'd4096, 0);
      drain("loopback");
      checks++; if (locked_a !== 1'b1) $display("[TB] FAIL loopback_locked got %b want 1", locked_a); else passes++;
      checks++; if (phaseinc_a !== 32'd4096) $display("[TB] FAIL loopback_hold got %0d want 4096", phaseinc_a); else passes++;
   endtask

   task automatic test_overrun();
      reset_dut();
      @(negedge clock);
      checks++; if (overrun_a !== 1'b0) $display("[TB] FAIL overrun_initial got %b want 0", overrun_a); else passes++;
      wave_a(8, 0, 12, 1'b0, 32'd32768, D_A + 1);
      drain("overrun");
      checks++; if (overrun_a !== 1'b1) $display("[TB] FAIL overrun_sticky got %b want 1", overrun_a); else passes++;
   endtask

   task automatic test_reset_mid_divide();
      int k;
      reset_dut();
      wave_a(64, 0, 2, 1'b0, 32'd0, 0);
      samp_a(32'sd30000, 0, k);
      @(negedge clock);
      en_a = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (40) @(negedge clock);
      checks++; if ({phaseinc_a, period_a, valid_a, locked_a, timeout_a, overrun_a} !== '0)
         $display("[TB] FAIL midreset_outputs got %h want 0",
                  {phaseinc_a, period_a, valid_a, locked_a, timeout_a, overrun_a}); else passes++;
      wave_a(64, 0, 3, 1'b0, 32'd4096, 0);
      drain("midreset");
   endtask

   task automatic test_slow_enable();
      reset_dut();
      wave_a(128, 3, 4, 1'b0, 32'd2048, 0);
      drain("slow_enable");
   endtask

   task automatic test_avg_alternating();
      int k;
      int p;
      exp_t e;
      reset_dut();
      for (int j = 0; j < 9; j++) begin
         p = (j % 2 == 0) ? 60 : 68;
         for (int i = 0; i < p; i++) begin
            samp_b((i < p/2) ? 32'sd2000 : -32'sd2000, k);
            if (i == 0 && j >= 3 && (j % 2) == 1) begin
               e.phaseinc = 32'd4096; e.period = 32'd128; e.tmo = 1'b0; e.lck = 1'b1; e.cyc = k + D_B + 2;
               q_b.push_back(e);
            end
         end
      end
      samp_b(32'sd2000, k);
      e.phaseinc = 32'd4096; e.period = 32'd128; e.tmo = 1'b0; e.lck = 1'b1; e.cyc = k + D_B + 2;
      q_b.push_back(e);
   endtask

   task automatic test_timeout();
      int k;
      exp_t e;
      for (int n = 1; n <= 275; n++) begin
         samp_b(32'(int'($urandom_range(1998)) - 999), k);
         if (n == 255) begin
            e.phaseinc = 32'd0; e.period = 32'd255; e.tmo = 1'b1; e.lck = 1'b0; e.cyc = k + 1;
            q_b.push_back(e);
         end
      end
      @(negedge clock);
      en_b = 1'b0;
      drain("timeout");
      checks++; if (locked_b !== 1'b0) $display("[TB] FAIL timeout_locked got %b want 0", locked_b); else passes++;
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_overrun();
      test_reset_mid_divide();
      test_slow_enable();
      test_avg_alternating();
      test_timeout();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
